execute_stage: RTL and testbench
================================

# execute_stage

Execute stage of the 5-stage pipeline. It sits between the ID/EX boundary and the memory stage. It resolves operand forwarding, runs the ALU and an iterative 32-cycle multiplier, and resolves branches. It holds the EX/MEM pipeline register whose outputs drive the memory stage's `Alu_out`, `DM_WD_M`, `DM_Write_M`, `Result_M`, `RF_WE_M` and `RD_M` inputs.

## Interface
- No parameters; datapath fixed at 32 bits, register index 5 bits.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `Valid_E` in 1: ID/EX holds a real instruction; 0 = bubble.
- `RD1_E`, `RD2_E` in 32: register-file operands.
- `Imm_E`, `PC_E` in 32: immediate and instruction PC.
- `RD_E` in 5: destination register.
- `ALUControl_E` in 4: operation select.
- `ALUSrc_E` in 1: 1 = SrcB is `Imm_E`.
- `RF_WE_E`, `DM_Write_E`, `ResultSrc_E`, `Branch_E` in 1 each: control bits.
- `ForwardA_E`, `ForwardB_E` in 2 each: operand source; 00 = register, 01 = `Result_WB`, 10 = `Alu_out`; 11 = register.
- `Result_WB` in 32: writeback result.
- `Flush_E` in 1: kill the instruction in EX.
- `Alu_out`, `DM_WD_M` out 32: EX/MEM ALU result and store data.
- `DM_Write_M`, `Result_M`, `RF_WE_M` out 1 each: EX/MEM control bits.
- `RD_M` out 5: EX/MEM destination register.
- `PCSrc_E` out 1: branch taken (combinational).
- `PCTarget_E` out 32: branch target (combinational).
- `Stall_E` out 1: upstream must hold ID/EX and the PC (combinational).

## Operation
- **Forwarded operands:** SrcA and the forwarded B value are selected by `ForwardA_E` and `ForwardB_E`. SrcB is `Imm_E` if `ALUSrc_E`, else the forwarded B value. `DM_WD_M` captures the forwarded B value, never the immediate.
- **ALU operations:**
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR.
  - 0101 SLT: signed compare, result 1 or 0.
  - 0110 SLL and 0111 SRL: shift amount is SrcB[4:0].
  - 1000 MUL: low 32 bits of the unsigned product.
  - Any other code gives 0.
  - All arithmetic is modulo 2^32.
- **Branch:** `PCSrc_E` = `Valid_E` & `Branch_E` & (SrcA == SrcB) & !`Flush_E`. `PCTarget_E` = `PC_E` + `Imm_E`, wrapping.
- **Multiplier FSM** (states IDLE, BUSY, DONE):
  - IDLE: if `Valid_E` & !`Flush_E` & MUL, latch multiplicand = SrcA and multiplier = SrcB, clear accumulator and count, go to BUSY. Operands are latched here because forwarded sources change while stalled.
  - BUSY: one shift-add step per cycle (add the multiplicand if multiplier bit 0 is set; shift multiplicand left and multiplier right). After step 32 (count 31), go to DONE.
  - DONE: go to IDLE.
  - `Flush_E` in BUSY or DONE forces IDLE.
- **Stall:** `Stall_E` = 1 in the IDLE cycle that starts a MUL and in every BUSY cycle. It is 0 in DONE and 0 otherwise.
- **EX/MEM register update, per cycle:**
  - `rst`: all outputs 0.
  - Else if `Flush_E`, or !`Valid_E`, or `Stall_E` = 1: load a bubble (`RF_WE_M` = `DM_Write_M` = 0; other fields 0).
  - Else if state is DONE: load the accumulator plus the current control, `RD_E` and store data.
  - Else: load the ALU result and the control fields.
- **MUL in DONE:** a MUL instruction seen in DONE never restarts the FSM. Only IDLE starts a multiply.

## Timing
- **Reset:** all EX/MEM outputs are 0 one edge after `rst` is sampled high. FSM goes to IDLE and count to 0. `Stall_E` = 0 after that edge.
- **Reset mid-MUL:** abort, IDLE, no product is ever emitted.
- **Single-cycle ops:** 1-cycle latency; inputs in cycle n appear on the EX/MEM outputs after edge n.
- **MUL:**
  - Occupies EX for 34 cycles: 1 start, 32 BUSY, 1 DONE.
  - `Stall_E` is high for 33 consecutive cycles.
  - 33 bubbles are emitted, then the product after the DONE edge.
- **Flush mid-MUL:** bubble on the next edge, IDLE, `Stall_E` low the same cycle `Flush_E` is high.
- **Flush and start together:** `Flush_E` with MUL start in IDLE gives no start and no stall.
- **Forward/WB change while stalled:** a `Result_WB` change during BUSY does not affect the product.

## Test plan
- **Reset:** drive `rst`=1 with garbage inputs -> all outputs 0, `Stall_E`=0; release, ADD 5+3 with `RD_E`=7 -> next edge `Alu_out`=8, `RD_M`=7, `RF_WE_M`=1.
- **Forwarding:**
  - `ForwardA_E`=10 with previous `Alu_out`=8, `RD2_E`=2, SUB -> `Alu_out`=6.
  - `ForwardB_E`=01 with `Result_WB`=0xFFFFFFFF, SLT with SrcA=0 -> 0.
  - SLT with SrcA=0xFFFFFFFE (−2) and SrcB=1 -> 1.
- **Store/immediate:** `ALUSrc_E`=1, `Imm_E`=0x10, `RD1_E`=0x100, `RD2_E`=0xAB, `DM_Write_E`=1 -> `Alu_out`=0x110, `DM_WD_M`=0xAB, `DM_Write_M`=1.
- **MUL:** 7×6, then 0xFFFFFFFF×2:
  - 7×6 -> `Stall_E` high exactly 33 cycles, 33 bubbles (`RF_WE_M`=0), then `Alu_out`=42 with `RF_WE_M`=1.
  - 0xFFFFFFFF×2 -> 0xFFFFFFFE.
  - Toggle `Result_WB` during BUSY -> result unchanged.
- **Abort:**
  - `Flush_E` at BUSY cycle 10 -> bubble, `Stall_E`=0 that cycle, next ADD completes normally.
  - Repeat with `rst` at BUSY cycle 20 -> all outputs 0, no product appears.
- **Branch:**
  - `Branch_E`=1, SrcA=SrcB=9, `PC_E`=0x40, `Imm_E`=0xFFFFFFF8 -> `PCSrc_E`=1, `PCTarget_E`=0x38.
  - Unequal operands -> `PCSrc_E`=0.
  - Same equal case with `Flush_E`=1 -> `PCSrc_E`=0.

Source files
------------

// File: rtl/execute_stage.sv
// Execute stage: operand forwarding, ALU, iterative 32-step shift-add multiplier,
// branch resolution and the EX/MEM pipeline register.
module execute_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        Valid_E,
    input  logic [31:0] RD1_E,
    input  logic [31:0] RD2_E,
    input  logic [31:0] Imm_E,
    input  logic [31:0] PC_E,
    input  logic [4:0]  RD_E,
    input  logic [3:0]  ALUControl_E,
    input  logic        ALUSrc_E,
    input  logic        RF_WE_E,
    input  logic        DM_Write_E,
    input  logic        ResultSrc_E,
    input  logic        Branch_E,
    input  logic [1:0]  ForwardA_E,
    input  logic [1:0]  ForwardB_E,
    input  logic [31:0] Result_WB,
    input  logic        Flush_E,
    output logic [31:0] Alu_out,
    output logic [31:0] DM_WD_M,
    output logic        DM_Write_M,
    output logic        Result_M,
    output logic        RF_WE_M,
    output logic [4:0]  RD_M,
    output logic        PCSrc_E,
    output logic [31:0] PCTarget_E,
    output logic        Stall_E
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_e;

    mul_state_e  state_q;
    logic [31:0] mcand_q, mplier_q, acc_q;
    logic [4:0]  count_q;

    logic [31:0] alu_out_q, alu_out_d;
    logic [31:0] dm_wd_q, dm_wd_d;
    logic        dm_write_q, dm_write_d;
    logic        result_q, result_d;
    logic        rf_we_q, rf_we_d;
    logic [4:0]  rd_q, rd_d;

    logic [31:0] src_a, fwd_b, src_b, alu_res;
    logic        is_mul, mul_start;

    always_comb begin
        case (ForwardA_E)
            2'b01:   src_a = Result_WB;
            2'b10:   src_a = alu_out_q;
            default: src_a = RD1_E;
        endcase
        case (ForwardB_E)
            2'b01:   fwd_b = Result_WB;
            2'b10:   fwd_b = alu_out_q;
            default: fwd_b = RD2_E;
        endcase
    end

    assign src_b  = ALUSrc_E ? Imm_E : fwd_b;
    assign is_mul = (ALUControl_E == 4'b1000);

    // Reset is folded in so no multiply can start, or stall upstream, while rst is held.
    assign mul_start = !rst && (state_q == IDLE) && Valid_E && !Flush_E && is_mul;
    assign Stall_E   = mul_start || (!rst && (state_q == BUSY) && !Flush_E);

    always_comb begin
        alu_res = '0;
        case (ALUControl_E)
            4'b0000: alu_res = src_a + src_b;
            4'b0001: alu_res = src_a - src_b;
            4'b0010: alu_res = src_a & src_b;
            4'b0011: alu_res = src_a | src_b;
            4'b0100: alu_res = src_a ^ src_b;
            4'b0101: alu_res = {31'b0, $signed(src_a) < $signed(src_b)};
            4'b0110: alu_res = src_a << src_b[4:0];
            4'b0111: alu_res = src_a >> src_b[4:0];
            default: alu_res = '0;
        endcase
    end

    assign PCSrc_E    = Valid_E && Branch_E && (src_a == src_b) && !Flush_E;
    assign PCTarget_E = PC_E + Imm_E;

    // Operands are captured at start because forwarded sources drift while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mul_start) begin
                        mcand_q  <= src_a;
                        mplier_q <= src_b;
                        acc_q    <= '0;
                        count_q  <= '0;
                        state_q  <= BUSY;
                    end
                end
                BUSY: begin
                    if (Flush_E) begin
                        state_q <= IDLE;
                    end else begin
                        if (mplier_q[0]) acc_q <= acc_q + mcand_q;
                        mcand_q  <= mcand_q << 1;
                        mplier_q <= mplier_q >> 1;
                        count_q  <= count_q + 5'd1;
                        if (count_q == 5'd31) state_q <= DONE;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        alu_out_d  = '0;
        dm_wd_d    = '0;
        dm_write_d = 1'b0;
        result_d   = 1'b0;
        rf_we_d    = 1'b0;
        rd_d       = '0;
        if (Valid_E && !Flush_E && !Stall_E) begin
            alu_out_d  = (state_q == DONE) ? acc_q : alu_res;
            dm_wd_d    = fwd_b;
            dm_write_d = DM_Write_E;
            result_d   = ResultSrc_E;
            rf_we_d    = RF_WE_E;
            rd_d       = RD_E;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_out_q  <= '0;
            dm_wd_q    <= '0;
            dm_write_q <= 1'b0;
            result_q   <= 1'b0;
            rf_we_q    <= 1'b0;
            rd_q       <= '0;
        end else begin
            alu_out_q  <= alu_out_d;
            dm_wd_q    <= dm_wd_d;
            dm_write_q <= dm_write_d;
            result_q   <= result_d;
            rf_we_q    <= rf_we_d;
            rd_q       <= rd_d;
        end
    end

    assign Alu_out    = alu_out_q;
    assign DM_WD_M    = dm_wd_q;
    assign DM_Write_M = dm_write_q;
    assign Result_M   = result_q;
    assign RF_WE_M    = rf_we_q;
    assign RD_M       = rd_q;

endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: directed vector table, multi-cycle MUL/flush/reset
// sequences, and randomized single-cycle ops against a reference model.
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        Valid_E;
    logic [31:0] RD1_E, RD2_E, Imm_E, PC_E;
    logic [4:0]  RD_E;
    logic [3:0]  ALUControl_E;
    logic        ALUSrc_E, RF_WE_E, DM_Write_E, ResultSrc_E, Branch_E;
    logic [1:0]  ForwardA_E, ForwardB_E;
    logic [31:0] Result_WB;
    logic        Flush_E;
    logic [31:0] Alu_out, DM_WD_M;
    logic        DM_Write_M, Result_M, RF_WE_M;
    logic [4:0]  RD_M;
    logic        PCSrc_E;
    logic [31:0] PCTarget_E;
    logic        Stall_E;

    int tests  = 0;
    int failed = 0;

    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    execute_stage dut (
        .clk(clk), .rst(rst), .Valid_E(Valid_E), .RD1_E(RD1_E), .RD2_E(RD2_E),
        .Imm_E(Imm_E), .PC_E(PC_E), .RD_E(RD_E), .ALUControl_E(ALUControl_E),
        .ALUSrc_E(ALUSrc_E), .RF_WE_E(RF_WE_E), .DM_Write_E(DM_Write_E),
        .ResultSrc_E(ResultSrc_E), .Branch_E(Branch_E), .ForwardA_E(ForwardA_E),
        .ForwardB_E(ForwardB_E), .Result_WB(Result_WB), .Flush_E(Flush_E),
        .Alu_out(Alu_out), .DM_WD_M(DM_WD_M), .DM_Write_M(DM_Write_M),
        .Result_M(Result_M), .RF_WE_M(RF_WE_M), .RD_M(RD_M), .PCSrc_E(PCSrc_E),
        .PCTarget_E(PCTarget_E), .Stall_E(Stall_E)
    );

    typedef struct {
        logic        valid;
        logic [31:0] rd1, rd2, imm, pc;
        logic [4:0]  rd;
        logic [3:0]  op;
        logic        alusrc, rfwe, dmw, rsrc, br;
        logic [1:0]  fa, fb;
        logic [31:0] wb;
        logic        flush;
        logic [31:0] e_alu, e_wd;
        logic        e_dmw, e_res, e_rfwe;
        logic [4:0]  e_rd;
        logic        e_pcsrc;
        logic [31:0] e_tgt;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs[NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        Valid_E = 1'b0; RD1_E = '0; RD2_E = '0; Imm_E = '0; PC_E = '0; RD_E = '0;
        ALUControl_E = '0; ALUSrc_E = 1'b0; RF_WE_E = 1'b0; DM_Write_E = 1'b0;
        ResultSrc_E = 1'b0; Branch_E = 1'b0; ForwardA_E = '0; ForwardB_E = '0;
        Result_WB = '0; Flush_E = 1'b0;
    endtask

    task automatic set_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd);
        set_idle();
        Valid_E = 1'b1; ALUControl_E = op; RD1_E = a; RD2_E = b; RD_E = rd; RF_WE_E = 1'b1;
    endtask

    task automatic check_regs(input string tag, input logic [31:0] alu, input logic [31:0] wd,
                              input logic dmw, input logic res, input logic rfwe,
                              input logic [4:0] rd);
        check({tag, "_alu"},  Alu_out, alu);
        check({tag, "_wd"},   DM_WD_M, wd);
        check({tag, "_dmw"},  32'(DM_Write_M), 32'(dmw));
        check({tag, "_res"},  32'(Result_M), 32'(res));
        check({tag, "_rfwe"}, 32'(RF_WE_M), 32'(rfwe));
        check({tag, "_rd"},   32'(RD_M), 32'(rd));
    endtask

    function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] reg_v,
                                         input logic [31:0] wb, input logic [31:0] prev);
        if (sel == 2'b01) return wb;
        if (sel == 2'b10) return prev;
        return reg_v;
    endfunction

    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        int sa, sb;
        sa = a; sb = b;
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return (sa < sb) ? 32'd1 : 32'd0;
            4'd6: return a << (b % 32);
            4'd7: return a >> (b % 32);
            default: return 32'd0;
        endcase
    endfunction

    // MUL with optional operand A coming from Result_WB, which is scrambled during BUSY.
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic via_wb,
                           input logic [4:0] rd);
        int stalls, bad;
        logic [31:0] prod;
        prod = a * b;
        set_op(4'd8, via_wb ? ~a : a, b, rd);
        if (via_wb) begin
            ForwardA_E = 2'b01;
            Result_WB  = a;
        end
        #1;
        check("mul_start_stall", 32'(Stall_E), 32'd1);
        stalls = 0;
        bad = 0;
        while (Stall_E === 1'b1 && stalls < 60) begin
            tick();
            if (RF_WE_M !== 1'b0 || Alu_out !== 32'd0) bad++;
            stalls++;
            if (via_wb) Result_WB = $urandom;
            #1;
        end
        check("mul_stall_cycles", 32'(stalls), 32'd33);
        check("mul_bubbles", 32'(bad), 32'd0);
        tick();
        check_regs("mul_done", prod, b, 1'b0, 1'b0, 1'b1, rd);
        set_idle();
    endtask

    initial begin
        vecs[0]  = '{1'b1, 32'd5, 32'd3, 32'd0, 32'd0, 5'd7, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 32'd0, 1'b0,
                     32'd8, 32'd3, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0, 32'd0};
        vecs[1]  = '{1'b1, 32'h999, 32'd2, 32'd4, 32'h100, 5'd8, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0, 32'd0, 1'b0,
                     32'd6, 32'd2, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 32'h104};
        vecs[2]  = '{1'b1, 32'd0, 32'h55, 32'd0, 32'd0, 5'd9, 4'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 32'hFFFFFFFF, 1'b0,
                     32'd0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 5'd9, 1'b0, 32'd0};
        vecs[3]  = '{1'b1, 32'hFFFFFFFE, 32'd1, 32'd0, 32'd0, 5'd10, 4'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 32'd0, 1'b0,
                     32'd1, 32'd1, 1'b0, 1'b0, 1'b1, 5'd10, 1'b0, 32'd0};
        vecs[4]  = '{1'b1, 32'h100, 32'hAB, 32'h10, 32'd0, 5'd0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 32'd0, 1'b0,
                     32'h110, 32'hAB, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 32'h10};
        vecs[5]  = '{1'b1, 32'd9, 32'd9, 32'hFFFFFFF8, 32'h40, 5'd0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 32'd0, 1'b0,
                     32'd0, 32'd9, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 32'h38};
        vecs[6]  = '{1'b1, 32'd9, 32'd8, 32'hFFFFFFF8, 32'h40, 5'd0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 32'd0, 1'b0,
                     32'd1, 32'd8, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h38};
        vecs[7]  = '{1'b1, 32'd9, 32'd9, 32'hFFFFFFF8, 32'h40, 5'd0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 32'd0, 1'b1,
                     32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h38};
        vecs[8]  = '{1'b1, 32'd1, 32'h24, 32'd0, 32'd0, 5'd11, 4'd6, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 32'd0, 1'b0,
                     32'h10, 32'h24, 1'b0, 1'b1, 1'b1, 5'd11, 1'b0, 32'd0};
        vecs[9]  = '{1'b1, 32'h80000000, 32'h77, 32'd31, 32'd0, 5'd12, 4'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 32'd0, 1'b0,
                     32'd1, 32'h77, 1'b0, 1'b0, 1'b1, 5'd12, 1'b0, 32'd31};
        vecs[10] = '{1'b1, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0, 32'd0, 5'd13, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 32'd0, 1'b0,
                     32'hF000F000, 32'hFF00FF00, 1'b0, 1'b0, 1'b1, 5'd13, 1'b0, 32'd0};
        vecs[11] = '{1'b1, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0, 32'd0, 5'd14, 4'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 32'd0, 1'b0,
                     32'hFFF0FFF0, 32'hFF00FF00, 1'b0, 1'b0, 1'b1, 5'd14, 1'b0, 32'd0};
        vecs[12] = '{1'b1, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0, 32'd0, 5'd15, 4'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 32'd0, 1'b0,
                     32'h0FF00FF0, 32'hFF00FF00, 1'b0, 1'b0, 1'b1, 5'd15, 1'b0, 32'd0};
        vecs[13] = '{1'b1, 32'd5, 32'd6, 32'd0, 32'd0, 5'd16, 4'd15, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 32'd0, 1'b0,
                     32'd0, 32'd6, 1'b0, 1'b0, 1'b1, 5'd16, 1'b0, 32'd0};
        vecs[14] = '{1'b0, 32'd1, 32'd1, 32'd0, 32'd0, 5'd17, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 32'd0, 1'b0,
                     32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0};
        vecs[15] = '{1'b1, 32'h55, 32'd7, 32'd0, 32'd0, 5'd18, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0, 32'd0, 1'b0,
                     32'd7, 32'd7, 1'b0, 1'b0, 1'b1, 5'd18, 1'b0, 32'd0};
        vecs[16] = '{1'b1, 32'd0, 32'd1, 32'd0, 32'd0, 5'd19, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 32'd0, 1'b0,
                     32'hFFFFFFFF, 32'd1, 1'b0, 1'b0, 1'b1, 5'd19, 1'b0, 32'd0};
        vecs[17] = '{1'b1, 32'hFFFFFFFF, 32'd2, 32'h20, 32'hFFFFFFF0, 5'd20, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 32'd0, 1'b0,
                     32'd1, 32'd2, 1'b0, 1'b0, 1'b1, 5'd20, 1'b0, 32'h10};

        // Reset with a valid MUL and garbage on every input.
        set_op(4'd8, 32'hDEADBEEF, 32'h12345678, 5'd31);
        DM_Write_E = 1'b1; ResultSrc_E = 1'b1; Result_WB = 32'hCAFEF00D;
        rst = 1'b1;
        tick();
        tick();
        check_regs("reset", 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        check("reset_stall", 32'(Stall_E), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            Valid_E = vecs[i].valid; RD1_E = vecs[i].rd1; RD2_E = vecs[i].rd2;
            Imm_E = vecs[i].imm; PC_E = vecs[i].pc; RD_E = vecs[i].rd;
            ALUControl_E = vecs[i].op; ALUSrc_E = vecs[i].alusrc; RF_WE_E = vecs[i].rfwe;
            DM_Write_E = vecs[i].dmw; ResultSrc_E = vecs[i].rsrc; Branch_E = vecs[i].br;
            ForwardA_E = vecs[i].fa; ForwardB_E = vecs[i].fb; Result_WB = vecs[i].wb;
            Flush_E = vecs[i].flush;
            #1;
            check($sformatf("vec%0d_pcsrc", i), 32'(PCSrc_E), 32'(vecs[i].e_pcsrc));
            check($sformatf("vec%0d_tgt", i), PCTarget_E, vecs[i].e_tgt);
            tick();
            check_regs($sformatf("vec%0d", i), vecs[i].e_alu, vecs[i].e_wd, vecs[i].e_dmw,
                       vecs[i].e_res, vecs[i].e_rfwe, vecs[i].e_rd);
        end

        set_idle();
        run_mul(32'd7, 32'd6, 1'b1, 5'd3);
        run_mul(32'hFFFFFFFF, 32'd2, 1'b0, 5'd4);
        run_mul($urandom, $urandom, 1'b1, 5'd5);

        // Flush at BUSY cycle 10.
        set_op(4'd8, 32'd5, 32'd5, 5'd6);
        tick();
        repeat (9) tick();
        Flush_E = 1'b1;
        #1;
        check("flush_stall_low", 32'(Stall_E), 32'd0);
        tick();
        check_regs("flush_bubble", 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        set_op(4'd0, 32'd2, 32'd3, 5'd21);
        #1;
        check("post_flush_stall", 32'(Stall_E), 32'd0);
        tick();
        check_regs("post_flush_add", 32'd5, 32'd3, 1'b0, 1'b0, 1'b1, 5'd21);

        // Reset at BUSY cycle 20.
        set_op(4'd8, 32'd9, 32'd9, 5'd7);
        tick();
        repeat (19) tick();
        rst = 1'b1;
        tick();
        check_regs("rst_mid_mul", 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        rst = 1'b0;
        set_op(4'd0, 32'd10, 32'd20, 5'd22);
        #1;
        check("post_rst_stall", 32'(Stall_E), 32'd0);
        tick();
        check_regs("post_rst_add", 32'd30, 32'd20, 1'b0, 1'b0, 1'b1, 5'd22);
        begin
            int bad = 0;
            set_idle();
            repeat (40) begin
                tick();
                if (RF_WE_M !== 1'b0 || Alu_out !== 32'd0 || Stall_E !== 1'b0) bad++;
            end
            check("rst_no_product", 32'(bad), 32'd0);
        end

        // Flush together with a MUL start.
        set_op(4'd8, 32'd3, 32'd3, 5'd8);
        Flush_E = 1'b1;
        #1;
        check("flush_start_stall", 32'(Stall_E), 32'd0);
        tick();
        check("flush_start_bubble", 32'(RF_WE_M), 32'd0);
        set_op(4'd0, 32'd1, 32'd1, 5'd23);
        #1;
        check("flush_start_nostall", 32'(Stall_E), 32'd0);
        tick();
        check_regs("flush_start_add", 32'd2, 32'd1, 1'b0, 1'b0, 1'b1, 5'd23);

        // Randomized single-cycle ops against the model.
        set_idle();
        tick();
        begin
            logic [31:0] m_prev, a, bf, b, e_alu, e_wd;
            logic        bubble, e_dmw, e_res, e_rfwe;
            logic [4:0]  e_rd;
            m_prev = 32'd0;
            for (int n = 0; n < 300; n++) begin
                Valid_E = ($urandom_range(0, 3) != 0);
                Flush_E = ($urandom_range(0, 7) == 0);
                ALUControl_E = 4'($urandom_range(0, 15));
                if (ALUControl_E == 4'd8) ALUControl_E = 4'd0;
                RD1_E = $urandom;
                RD2_E = ($urandom_range(0, 3) == 0) ? RD1_E : $urandom;
                Imm_E = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 40)) : $urandom;
                PC_E = $urandom; RD_E = 5'($urandom_range(0, 31));
                ALUSrc_E = 1'($urandom_range(0, 1)); RF_WE_E = 1'($urandom_range(0, 1));
                DM_Write_E = 1'($urandom_range(0, 1)); ResultSrc_E = 1'($urandom_range(0, 1));
                Branch_E = 1'($urandom_range(0, 1));
                ForwardA_E = 2'($urandom_range(0, 3)); ForwardB_E = 2'($urandom_range(0, 3));
                Result_WB = $urandom;

                a  = pick(ForwardA_E, RD1_E, Result_WB, m_prev);
                bf = pick(ForwardB_E, RD2_E, Result_WB, m_prev);
                b  = ALUSrc_E ? Imm_E : bf;
                bubble = !Valid_E || Flush_E;
                e_alu  = bubble ? 32'd0 : alu_ref(ALUControl_E, a, b);
                e_wd   = bubble ? 32'd0 : bf;
                e_dmw  = bubble ? 1'b0 : DM_Write_E;
                e_res  = bubble ? 1'b0 : ResultSrc_E;
                e_rfwe = bubble ? 1'b0 : RF_WE_E;
                e_rd   = bubble ? 5'd0 : RD_E;
                exp_q.push_back(e_alu);

                #1;
                check("rnd_pcsrc", 32'(PCSrc_E),
                      32'(Valid_E && Branch_E && !Flush_E && (a == b)));
                check("rnd_tgt", PCTarget_E, PC_E + Imm_E);
                check("rnd_stall", 32'(Stall_E), 32'd0);
                tick();
                m_prev = exp_q.pop_front();
                check_regs("rnd", m_prev, e_wd, e_dmw, e_res, e_rfwe, e_rd);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
